// File: rtl/context_memory_dbuf.sv
// Double-buffered context store: the core fetches from the active bank while a loader streams
// the next image into the shadow bank, and the two banks swap on request without stalling fetches.
module context_memory_dbuf #(
    parameter int CONTEXT_WIDTH = 32,
    parameter int CONTEXT_DEPTH = 256,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     EN_I,
    input  logic [ADDR_WIDTH-1:0]    PC_I,
    output logic [CONTEXT_WIDTH-1:0] DATA_O,
    output logic                     DATA_VALID_O,
    output logic                     PC_OOR_O,
    input  logic [CONTEXT_WIDTH-1:0] LOAD_DATA_I,
    input  logic                     LOAD_VALID_I,
    input  logic                     LOAD_LAST_I,
    output logic                     LOAD_READY_O,
    input  logic                     SWAP_I,
    output logic                     SWAP_ACK_O,
    output logic                     SHADOW_FULL_O,
    output logic [ADDR_WIDTH:0]      ACTIVE_LEN_O,
    output logic                     LOAD_OVF_O
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} ld_state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CONTEXT_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEN  = (ADDR_WIDTH + 1)'(CONTEXT_DEPTH);

    logic [CONTEXT_WIDTH-1:0] mem [0:2*CONTEXT_DEPTH-1];

    ld_state_t             state_q, state_d;
    logic                  act_sel;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   shadow_len;
    logic [ADDR_WIDTH:0]   active_len;
    logic                  xfer;
    logic                  swap_go;
    logic                  ovf_hit;
    logic                  pc_in_range;

    // Ready is forced low while reset is held so nothing is accepted into a discarded image.
    assign LOAD_READY_O  = (state_q != FULL) && !RST_I;
    assign xfer          = LOAD_VALID_I && LOAD_READY_O;
    assign swap_go       = (state_q == FULL) && SWAP_I;
    assign pc_in_range   = {1'b0, PC_I} < active_len;
    assign SHADOW_FULL_O = (state_q == FULL);
    assign ACTIVE_LEN_O  = active_len;

    always_comb begin
        state_d = state_q;
        ovf_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) state_d = LOAD_LAST_I ? FULL : LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    if (LOAD_LAST_I) begin
                        state_d = FULL;
                    end else if (wr_ptr == LAST_ADDR) begin
                        state_d = FULL;
                        ovf_hit = 1'b1;
                    end
                end
            end
            FULL: begin
                if (SWAP_I) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr     <= '0;
            act_sel    <= 1'b0;
            active_len <= '0;
            shadow_len <= '0;
            LOAD_OVF_O <= 1'b0;
            SWAP_ACK_O <= 1'b0;
        end else begin
            SWAP_ACK_O <= swap_go;
            if (ovf_hit) LOAD_OVF_O <= 1'b1;
            if (xfer) begin
                if (state_d == FULL) begin
                    wr_ptr     <= '0;
                    shadow_len <= ovf_hit ? FULL_LEN : ({1'b0, wr_ptr} + (ADDR_WIDTH + 1)'(1));
                end else begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
            end
            if (swap_go) begin
                act_sel    <= ~act_sel;
                active_len <= shadow_len;
            end
        end
    end

    // Loader always writes the shadow bank, so it never collides with a fetch.
    always_ff @(posedge CLK_I) begin
        if (xfer) mem[{~act_sel, wr_ptr}] <= LOAD_DATA_I;
    end

    // Fetch sees pre-edge act_sel/active_len, so a fetch on the swap edge still reads the old bank.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            DATA_O       <= '0;
            DATA_VALID_O <= 1'b0;
            PC_OOR_O     <= 1'b0;
        end else if (EN_I) begin
            DATA_O       <= pc_in_range ? mem[{act_sel, PC_I}] : '0;
            DATA_VALID_O <= pc_in_range;
            PC_OOR_O     <= !pc_in_range;
        end else begin
            DATA_VALID_O <= 1'b0;
            PC_OOR_O     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_context_memory_dbuf.sv
// Self-checking bench for context_memory_dbuf: randomized fetch/load/swap traffic compared
// against a queue-based model of the active and shadow images.
module tb_context_memory_dbuf;

    localparam int W  = 32;
    localparam int D  = 256;
    localparam int AW = 8;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic          EN_I = 1'b0;
    logic [AW-1:0] PC_I = '0;
    logic [W-1:0]  DATA_O;
    logic          DATA_VALID_O;
    logic          PC_OOR_O;
    logic [W-1:0]  LOAD_DATA_I = '0;
    logic          LOAD_VALID_I = 1'b0;
    logic          LOAD_LAST_I = 1'b0;
    logic          LOAD_READY_O;
    logic          SWAP_I = 1'b0;
    logic          SWAP_ACK_O;
    logic          SHADOW_FULL_O;
    logic [AW:0]   ACTIVE_LEN_O;
    logic          LOAD_OVF_O;

    always #5 CLK_I = ~CLK_I;

    context_memory_dbuf #(.CONTEXT_WIDTH(W), .CONTEXT_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .PC_I(PC_I),
        .DATA_O(DATA_O), .DATA_VALID_O(DATA_VALID_O), .PC_OOR_O(PC_OOR_O),
        .LOAD_DATA_I(LOAD_DATA_I), .LOAD_VALID_I(LOAD_VALID_I), .LOAD_LAST_I(LOAD_LAST_I),
        .LOAD_READY_O(LOAD_READY_O), .SWAP_I(SWAP_I), .SWAP_ACK_O(SWAP_ACK_O),
        .SHADOW_FULL_O(SHADOW_FULL_O), .ACTIVE_LEN_O(ACTIVE_LEN_O), .LOAD_OVF_O(LOAD_OVF_O)
    );

    // Reference model: images as queues, plus the expected registered fetch outputs.
    logic [W-1:0] act_img[$];
    logic [W-1:0] sh_img[$];
    logic         m_full = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_valid = 1'b0;
    logic         exp_oor = 1'b0;
    logic         exp_ack = 1'b0;
    logic         ready_seen;
    logic         ready_exp;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W+13:0] obs_vec();
        return {DATA_O, DATA_VALID_O, PC_OOR_O, SWAP_ACK_O, SHADOW_FULL_O, LOAD_OVF_O, ACTIVE_LEN_O};
    endfunction

    function automatic logic [W+13:0] exp_vec();
        return {exp_data, exp_valid, exp_oor, exp_ack, m_full, m_ovf, (AW + 1)'(act_img.size())};
    endfunction

    task automatic drive_cycle(input logic rst, input logic en, input logic [AW-1:0] pc,
                               input logic lv, input logic [W-1:0] ld, input logic ll,
                               input logic sw);
        RST_I = rst; EN_I = en; PC_I = pc;
        LOAD_VALID_I = lv; LOAD_DATA_I = ld; LOAD_LAST_I = ll; SWAP_I = sw;
        @(negedge CLK_I);
        ready_seen = LOAD_READY_O;
        ready_exp  = !rst && !m_full;
        if (rst) begin
            exp_data = '0; exp_valid = 1'b0; exp_oor = 1'b0; exp_ack = 1'b0;
            act_img.delete(); sh_img.delete();
            m_full = 1'b0; m_ovf = 1'b0;
        end else begin
            if (en) begin
                exp_valid = (int'(pc) < act_img.size());
                exp_oor   = !exp_valid;
                exp_data  = exp_valid ? act_img[pc] : '0;
            end else begin
                exp_valid = 1'b0; exp_oor = 1'b0;
            end
            exp_ack = 1'b0;
            if (sw && m_full) begin
                act_img = sh_img;
                sh_img.delete();
                m_full  = 1'b0;
                exp_ack = 1'b1;
            end else if (lv && !m_full) begin
                sh_img.push_back(ld);
                if (ll) m_full = 1'b1;
                else if (sh_img.size() == D) begin
                    m_full = 1'b1; m_ovf = 1'b1;
                end
            end
        end
        @(posedge CLK_I);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, '0, 1'b1, 32'h55, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_outputs cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (ready_seen !== 1'b0) begin
                errors++; $display("FAIL reset_ready cyc%0d: got %b want 0", i, ready_seen);
            end
        end
        drive_cycle(1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (DATA_O !== '0 || PC_OOR_O !== 1'b1 || DATA_VALID_O !== 1'b0 || ACTIVE_LEN_O !== '0) begin
            errors++;
            $display("FAIL first_fetch_oor: got data=%h oor=%b vld=%b len=%0d want 0/1/0/0",
                     DATA_O, PC_OOR_O, DATA_VALID_O, ACTIVE_LEN_O);
        end
        checks++;
        if (ready_seen !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b want 1", ready_seen);
        end
    endtask

    task automatic test_basic_load();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, '0, 1'b1, 32'hA0 + i, (i == 3), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || ready_seen !== ready_exp) begin
                errors++; $display("FAIL basic_load w%0d: got %h/%b want %h/%b", i, obs_vec(), ready_seen, exp_vec(), ready_exp);
            end
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (SWAP_ACK_O !== 1'b1 || ACTIVE_LEN_O !== 9'd4) begin
            errors++; $display("FAIL basic_swap: got ack=%b len=%0d want 1/4", SWAP_ACK_O, ACTIVE_LEN_O);
        end
        for (int pc = 0; pc <= 4; pc++) begin
            drive_cycle(1'b0, 1'b1, AW'(pc), 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (DATA_O !== ((pc < 4) ? 32'hA0 + pc : 32'h0) || DATA_VALID_O !== (pc < 4) ||
                PC_OOR_O !== (pc == 4) || SWAP_ACK_O !== 1'b0) begin
                errors++;
                $display("FAIL basic_fetch pc%0d: got data=%h vld=%b oor=%b ack=%b", pc, DATA_O, DATA_VALID_O, PC_OOR_O, SWAP_ACK_O);
            end
        end
    endtask

    task automatic test_stream_swap();
        logic [W-1:0] a_img[$];
        logic [W-1:0] b_img[$];
        a_img = act_img;
        for (int i = 0; i < 6; i++) b_img.push_back($urandom);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b1, AW'($urandom_range(0, 6)), 1'b1, b_img[i], (i == 5), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || ready_seen !== ready_exp) begin
                errors++; $display("FAIL stream_load w%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        drive_cycle(1'b0, 1'b1, AW'(2), 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (DATA_O !== a_img[2] || DATA_VALID_O !== 1'b1 || SWAP_ACK_O !== 1'b1) begin
            errors++; $display("FAIL swap_edge_fetch: got %h vld=%b want %h", DATA_O, DATA_VALID_O, a_img[2]);
        end
        drive_cycle(1'b0, 1'b1, AW'(2), 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (DATA_O !== b_img[2] || DATA_VALID_O !== 1'b1 || ACTIVE_LEN_O !== 9'd6) begin
            errors++; $display("FAIL post_swap_fetch: got %h len=%0d want %h len=6", DATA_O, ACTIVE_LEN_O, b_img[2]);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 8)), 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stream_fetch c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_swap_during_load();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, AW'($urandom_range(0, 7)), 1'b1, $urandom, (i == 4), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL partial_load w%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                drive_cycle(1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
                checks++;
                if (SWAP_ACK_O !== 1'b0 || ACTIVE_LEN_O !== 9'd6 || obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL swap_ignored: got ack=%b len=%0d want 0/6", SWAP_ACK_O, ACTIVE_LEN_O);
                end
            end
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (SWAP_ACK_O !== 1'b1 || ACTIVE_LEN_O !== 9'd5) begin
            errors++; $display("FAIL swap_after_load: got ack=%b len=%0d want 1/5", SWAP_ACK_O, ACTIVE_LEN_O);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < D + 3; i++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), 1'b1, $urandom, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || ready_seen !== (i < D)) begin
                errors++; $display("FAIL overflow_stream w%0d: got %h rdy=%b want %h rdy=%b", i, obs_vec(), ready_seen, exp_vec(), (i < D));
            end
        end
        checks++;
        if (LOAD_OVF_O !== 1'b1 || SHADOW_FULL_O !== 1'b1) begin
            errors++; $display("FAIL overflow_flags: got ovf=%b full=%b want 1/1", LOAD_OVF_O, SHADOW_FULL_O);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (ACTIVE_LEN_O !== 9'(D) || SWAP_ACK_O !== 1'b1 || LOAD_OVF_O !== 1'b1) begin
            errors++; $display("FAIL overflow_swap: got len=%0d ack=%b ovf=%b want %0d/1/1", ACTIVE_LEN_O, SWAP_ACK_O, LOAD_OVF_O, D);
        end
    endtask

    task automatic test_reset_midload();
        for (int r = 0; r < 2; r++) begin
            int n;
            int guard;
            for (int i = 0; i < 3; i++)
                drive_cycle(1'b0, 1'b0, '0, 1'b1, $urandom, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                drive_cycle(1'b1, 1'b1, '0, 1'b1, $urandom, 1'b0, 1'b0);
                checks++;
                if (ready_seen !== 1'b0 || obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL midload_reset r%0d: got %h rdy=%b want %h rdy=0", r, obs_vec(), ready_seen, exp_vec());
                end
            end
            n = 0;
            guard = 0;
            while (n < 2 && guard < 100) begin
                logic lv;
                logic ll;
                lv = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                ll = lv ? (n == 1) : 1'($urandom_range(0, 1));
                drive_cycle(1'b0, 1'b1, AW'($urandom_range(0, 3)), lv, lv ? 32'h11 * (n + 1) : 32'hDEAD, ll, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec() || ready_seen !== ready_exp) begin
                    errors++; $display("FAIL fresh_load r%0d: got %h want %h", r, obs_vec(), exp_vec());
                end
                if (lv) n++;
                guard++;
            end
            checks++;
            if (n != 2) begin
                errors++; $display("FAIL fresh_load_timeout r%0d: got %0d words want 2", r, n);
            end
            drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
            checks++;
            if (ACTIVE_LEN_O !== 9'd2 || SWAP_ACK_O !== 1'b1 || LOAD_OVF_O !== 1'b0) begin
                errors++; $display("FAIL fresh_swap r%0d: got len=%0d ack=%b ovf=%b want 2/1/0", r, ACTIVE_LEN_O, SWAP_ACK_O, LOAD_OVF_O);
            end
            for (int pc = 0; pc < 3; pc++) begin
                drive_cycle(1'b0, 1'b1, AW'(pc), 1'b0, '0, 1'b0, 1'b0);
                checks++;
                if (DATA_O !== ((pc < 2) ? 32'h11 * (pc + 1) : 32'h0) || PC_OOR_O !== (pc == 2)) begin
                    errors++; $display("FAIL fresh_fetch r%0d pc%0d: got %h oor=%b", r, pc, DATA_O, PC_OOR_O);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stream_swap();
        test_swap_during_load();
        test_overflow();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
